// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder: pass-through to the dmem syncram below MMIO_BASE, local registers above it.
// Define MMIO_DBG_FIFO_EN to build the debug TX FIFO; without it DBG_TX writes are discarded.
module dmem_mmio_responder #(
  parameter int                ADDR_W     = 12,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] MMIO_BASE  = 12'hFF0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_dmem,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q_dmem,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_valid,
  input  logic              dbg_ready,
  output logic              irq
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic              mmio;
  logic [3:0]        off;
  logic              wr_cycle, wr_tcmp, wr_status, wr_dbg, wr_scratch;
  logic [DATA_W-1:0] counter, tcmp, scratch, rd_q, rd_val;
  logic              timer_hit, overflow, sel_mmio, hit_set;
  logic              fifo_full, fifo_empty, ovf_set;
  logic [3:0]        fifo_count;

  // The window is 16 words, so only the low nibble of the offset matters.
  assign mmio = (address_dmem >= MMIO_BASE);
  assign off  = address_dmem[3:0] - MMIO_BASE[3:0];

  assign wr_cycle   = wren & mmio & (off == 4'h0);
  assign wr_tcmp    = wren & mmio & (off == 4'h1);
  assign wr_status  = wren & mmio & (off == 4'h2);
  assign wr_dbg     = wren & mmio & (off == 4'h3);
  assign wr_scratch = wren & mmio & (off == 4'h4);

  assign mem_address = address_dmem;
  assign mem_data    = data;
  assign mem_wren    = wren & ~mmio & ~reset;

  assign hit_set = (counter == tcmp) && (tcmp != '0);

`ifdef MMIO_DBG_FIFO_EN
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push, pop;

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign pop        = ~fifo_empty & dbg_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push       = wr_dbg & (~fifo_full | pop);
  assign ovf_set    = wr_dbg & fifo_full & ~pop;
  assign dbg_valid  = ~fifo_empty;
  assign dbg_data   = fifo_mem[rd_ptr];
  assign fifo_count = 4'(count);

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
`else
  logic [1:0] unused_fifo_inputs;
  assign unused_fifo_inputs = {dbg_ready, wr_dbg};
  assign fifo_full  = 1'b0;
  assign fifo_empty = 1'b1;
  assign ovf_set    = 1'b0;
  assign dbg_valid  = 1'b0;
  assign dbg_data   = '0;
  assign fifo_count = 4'h0;
`endif

  always_comb begin
    rd_val = '0;
    case (off)
      4'h0: rd_val = counter;
      4'h1: rd_val = tcmp;
      4'h2: begin
        rd_val[0]   = timer_hit;
        rd_val[1]   = fifo_full;
        rd_val[2]   = fifo_empty;
        rd_val[3]   = overflow;
        rd_val[7:4] = fifo_count;
      end
      4'h4: rd_val = scratch;
      default: rd_val = '0;
    endcase
  end

  // Read data is captured from pre-update state, matching the syncram's one-cycle latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      counter   <= '0;
      tcmp      <= '0;
      scratch   <= '0;
      timer_hit <= 1'b0;
      overflow  <= 1'b0;
      sel_mmio  <= 1'b0;
      rd_q      <= '0;
    end else begin
      sel_mmio  <= mmio;
      rd_q      <= rd_val;
      counter   <= wr_cycle ? '0 : counter + DATA_W'(1);
      if (wr_tcmp)    tcmp    <= data;
      if (wr_scratch) scratch <= data;
      timer_hit <= hit_set | (timer_hit & ~(wr_status & data[0]));
      overflow  <= ovf_set | (overflow & ~(wr_status & data[3]));
    end
  end

  assign q_dmem = sel_mmio ? rd_q : mem_q;
  assign irq    = timer_hit;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: queue-based register/FIFO model checked every cycle, plus directed literals.
// Follows MMIO_DBG_FIFO_EN the same way the design does.
module tb_dmem_mmio_responder;

  localparam int DEPTH = 4;
  localparam logic [11:0] BASE = 12'hFF0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic        dbg_ready = 1'b0;
  logic [31:0] q_dmem, mem_data, mem_q, dbg_data;
  logic [11:0] mem_address;
  logic        mem_wren, dbg_valid, irq;

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  dmem_mmio_responder dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
    .wren(wren), .q_dmem(q_dmem), .mem_address(mem_address), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q), .dbg_data(dbg_data), .dbg_valid(dbg_valid),
    .dbg_ready(dbg_ready), .irq(irq)
  );

  always #5 clock = ~clock;

  // Environment syncram: one-cycle read, old data on read-during-write.
  logic [31:0] ram [0:4095];
  always @(posedge clock) begin
    mem_q <= ram[mem_address];
    if (mem_wren) ram[mem_address] <= mem_data;
  end

  // Reference model state
  logic [31:0] m_counter, m_tcmp, m_scratch, exp_q;
  bit          m_hit, m_ovf;
  logic [31:0] m_fifo[$];
  logic [31:0] shadow [0:4095];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = '0;
      shadow[i] = '0;
    end
    mem_q = '0;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on each edge from the pre-edge state and the inputs of that cycle.
  always @(posedge clock) begin
    bit          mm, wr, full, empty, pop, preq, hset;
    logic [3:0]  off;
    logic [31:0] rv, st;
    int          size;
    mm  = (address_dmem >= BASE);
    off = 4'(address_dmem - BASE);
    wr  = wren && mm;
    if (reset) begin
      m_counter = 0; m_tcmp = 0; m_scratch = 0; m_hit = 0; m_ovf = 0;
      m_fifo.delete();
      exp_q = shadow[address_dmem];
    end else begin
      size  = m_fifo.size();
      full  = (size == DEPTH);
      empty = (size == 0);
      st = 32'(m_hit) | (32'(full) << 1) | (32'(empty) << 2) | (32'(m_ovf) << 3) | (32'(size) << 4);
      case (off)
        4'h0: rv = m_counter;
        4'h1: rv = m_tcmp;
        4'h2: rv = st;
        4'h4: rv = m_scratch;
        default: rv = 0;
      endcase
      exp_q = mm ? rv : shadow[address_dmem];
      if (wren && !mm) shadow[address_dmem] = data;
      hset = (m_counter == m_tcmp) && (m_tcmp != 0);
      preq = wr && (off == 4'h3);
`ifdef MMIO_DBG_FIFO_EN
      pop = !empty && dbg_ready;
`else
      pop = 0;
      preq = 0;
`endif
      m_hit = hset || (m_hit && !(wr && off == 4'h2 && data[0]));
      m_ovf = (preq && full && !pop) || (m_ovf && !(wr && off == 4'h2 && data[3]));
      if (pop) void'(m_fifo.pop_front());
      if (preq && (!full || pop)) m_fifo.push_back(data);
      m_counter = (wr && off == 4'h0) ? 32'd0 : m_counter + 32'd1;
      if (wr && off == 4'h1) m_tcmp = data;
      if (wr && off == 4'h4) m_scratch = data;
    end
  end

  // Outputs are compared mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (checking) begin
      checkOutput("mem_address", 32'(mem_address), 32'(address_dmem));
      checkOutput("mem_data", mem_data, data);
      checkOutput("mem_wren", 32'(mem_wren), 32'(wren && (address_dmem < BASE) && !reset));
      checkOutput("q_dmem", q_dmem, exp_q);
      checkOutput("irq", 32'(irq), 32'(m_hit));
      checkOutput("dbg_valid", 32'(dbg_valid), 32'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) checkOutput("dbg_data", dbg_data, m_fifo[0]);
`ifndef MMIO_DBG_FIFO_EN
      checkOutput("dbg_data_tied", dbg_data, 32'd0);
`endif
    end
  end

  task automatic drive(input logic [11:0] a, input logic [31:0] d, input logic w);
    address_dmem = a;
    data = d;
    wren = w;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [11:0] a, input logic [31:0] d, input logic w);
    drive(a, d, w);
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(12'h000, 32'd0, 1'b0);
  endtask

  initial begin
    logic [11:0] a;
    logic [31:0] d;

    reset = 1'b1;
    applyStimulus(12'h000, 32'd0, 1'b0);
    checking = 1;
    applyStimulus(12'h000, 32'd0, 1'b0);
    reset = 1'b0;

    // Counter starts at 0 on the first cycle out of reset
    idle(10);
    applyStimulus(BASE + 12'h0, 32'd0, 1'b0);
    checkOutput("cycle_at_10", q_dmem, 32'd10);
    applyStimulus(BASE + 12'h0, 32'h1234, 1'b1);
    idle(4);
    applyStimulus(BASE + 12'h0, 32'd0, 1'b0);
    checkOutput("cycle_after_clear", q_dmem, 32'd4);

    // Timer hit one cycle after the count reaches TCMP
    applyStimulus(BASE + 12'h0, 32'd0, 1'b1);
    applyStimulus(BASE + 12'h1, 32'd20, 1'b1);
    idle(19);
    checkOutput("irq_before_hit", 32'(irq), 32'd0);
    idle(1);
    checkOutput("irq_hit", 32'(irq), 32'd1);
    applyStimulus(BASE + 12'h2, 32'd1, 1'b1);
    checkOutput("irq_cleared", 32'(irq), 32'd0);
    applyStimulus(BASE + 12'h0, 32'd0, 1'b1);
    applyStimulus(BASE + 12'h1, 32'd5, 1'b1);
    idle(4);
    checkOutput("irq_before_race", 32'(irq), 32'd0);
    applyStimulus(BASE + 12'h2, 32'd1, 1'b1);
    checkOutput("irq_set_wins", 32'(irq), 32'd1);

`ifdef MMIO_DBG_FIFO_EN
    dbg_ready = 1'b0;
    for (int i = 1; i <= 5; i++) applyStimulus(BASE + 12'h3, 32'(i), 1'b1);
    applyStimulus(BASE + 12'h2, 32'd0, 1'b0);
    checkOutput("status_full_ovf", q_dmem & 32'hFE, 32'h4A);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("drain_data", dbg_data, 32'(i));
      dbg_ready = 1'b1;
      applyStimulus(12'h000, 32'd0, 1'b0);
    end
    checkOutput("drained_valid", 32'(dbg_valid), 32'd0);
    dbg_ready = 1'b0;
    applyStimulus(BASE + 12'h2, 32'h8, 1'b1);
    for (int i = 10; i <= 13; i++) applyStimulus(BASE + 12'h3, 32'(i), 1'b1);
    dbg_ready = 1'b1;
    applyStimulus(BASE + 12'h3, 32'd9, 1'b1);
    dbg_ready = 1'b0;
    applyStimulus(BASE + 12'h2, 32'd0, 1'b0);
    checkOutput("status_push_pop_full", q_dmem & 32'hFE, 32'h42);
    dbg_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain2_data", dbg_data, (i == 3) ? 32'd9 : 32'(11 + i));
      applyStimulus(12'h000, 32'd0, 1'b0);
    end
    dbg_ready = 1'b0;
`else
    applyStimulus(BASE + 12'h3, 32'd77, 1'b1);
    applyStimulus(BASE + 12'h2, 32'd0, 1'b0);
    checkOutput("status_no_fifo", q_dmem & 32'hFE, 32'h04);
    checkOutput("no_fifo_valid", 32'(dbg_valid), 32'd0);
`endif

    // Pass-through and window edges
    drive(12'h010, 32'hDEADBEEF, 1'b1);
    #1 checkOutput("mem_wren_pulse", 32'(mem_wren), 32'd1);
    step();
    drive(12'h010, 32'd0, 1'b0);
    #1 checkOutput("mem_wren_low", 32'(mem_wren), 32'd0);
    step();
    checkOutput("passthru_read", q_dmem, 32'hDEADBEEF);
    applyStimulus(12'hFEF, 32'h00C0FFEE, 1'b1);
    applyStimulus(12'hFEF, 32'd0, 1'b0);
    checkOutput("read_fef", q_dmem, 32'h00C0FFEE);
    applyStimulus(BASE + 12'h7, 32'hFFFFFFFF, 1'b1);
    applyStimulus(BASE + 12'h7, 32'd0, 1'b0);
    checkOutput("read_ff7", q_dmem, 32'd0);
    drive(BASE + 12'h4, 32'h5A5A5A5A, 1'b1);
    #1 checkOutput("scratch_no_memwren", 32'(mem_wren), 32'd0);
    step();
    applyStimulus(BASE + 12'h4, 32'd0, 1'b0);
    checkOutput("scratch_read", q_dmem, 32'h5A5A5A5A);

    // Reset mid-sequence clears every register and the FIFO
    applyStimulus(BASE + 12'h1, 32'h99, 1'b1);
    applyStimulus(BASE + 12'h3, 32'h55, 1'b1);
    reset = 1'b1;
    applyStimulus(BASE + 12'h4, 32'h0, 1'b0);
    reset = 1'b0;
    checkOutput("rst_dbg_valid", 32'(dbg_valid), 32'd0);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    applyStimulus(BASE + 12'h0, 32'd0, 1'b0);
    checkOutput("rst_cycle", q_dmem, 32'd0);
    applyStimulus(BASE + 12'h4, 32'd0, 1'b0);
    checkOutput("rst_scratch", q_dmem, 32'd0);
    applyStimulus(BASE + 12'h1, 32'd0, 1'b0);
    checkOutput("rst_tcmp", q_dmem, 32'd0);
    applyStimulus(BASE + 12'h2, 32'd0, 1'b0);
    checkOutput("rst_status", q_dmem, 32'h04);

    // Randomized traffic checked against the model
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0, 1: a = BASE + 12'($urandom_range(0, 7));
        2: a = 12'($urandom_range(0, 15));
        default: a = ($urandom_range(0, 1) != 0) ? 12'hFE8 + 12'($urandom_range(0, 7))
                                                 : 12'hFF8 + 12'($urandom_range(0, 7));
      endcase
      d = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
      dbg_ready = ($urandom_range(0, 1) != 0);
      reset = ($urandom_range(0, 299) == 0);
      applyStimulus(a, d, ($urandom_range(0, 2) != 0));
    end
    reset = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder on the processor's data-memory port: address_dmem / data / wren in, q_dmem out.
- Sits between the processor and the dmem syncram.
- Addresses below MMIO_BASE pass through to dmem. Addresses at or above MMIO_BASE are answered by local registers: cycle counter, timer compare, status, scratch, and a debug TX FIFO drained over a valid/ready port.
- MMIO reads match the dmem syncram's one-cycle read latency, so the processor sees a single uniform memory timing.

Parameters:
- ADDR_W, 12, data-memory word-address width.
- DATA_W, 32, data word width.
- MMIO_BASE, 12'hFF0, first word address of the MMIO window; window size 16 words.
- FIFO_DEPTH, 4, debug TX FIFO entries; power of two, 2..8.

Ports:
- clock  in  1  single clock for all state; same edge as dmem_clock.
- reset  in  1  synchronous, active-high.
- address_dmem  in  ADDR_W  word address from processor.
- data  in  DATA_W  write data from processor.
- wren  in  1  write enable from processor.
- q_dmem  out  DATA_W  read data to processor.
- mem_address  out  ADDR_W  address to dmem syncram.
- mem_data  out  DATA_W  write data to dmem syncram.
- mem_wren  out  1  write enable to dmem syncram.
- mem_q  in  DATA_W  read data from dmem syncram.
- dbg_data  out  DATA_W  FIFO head word.
- dbg_valid  out  1  FIFO non-empty.
- dbg_ready  in  1  sink accepts the head word.
- irq  out  1  timer-hit flag.

Behaviour:
- Decode (combinational): mmio = (address_dmem >= MMIO_BASE); off = address_dmem - MMIO_BASE, 4 bits.
- mem_address = address_dmem and mem_data = data, always driven. mem_wren = wren & ~mmio.
- Read path, 1-cycle latency:
  - Each cycle, register sel_mmio <= mmio and rd_q <= MMIO read value at off.
  - Values are sampled at the request cycle, before that cycle's register updates.
  - q_dmem = sel_mmio ? rd_q : mem_q.
- MMIO map:
  - 0x0 CYCLE: read = counter. Any write clears the counter to 0 next cycle; the write data is ignored.
  - 0x1 TCMP: r/w, 32 bits.
  - 0x2 STATUS: bit0 timer_hit (sticky); bit1 fifo_full; bit2 fifo_empty; bit3 overflow (sticky); bits[7:4] fifo count; rest 0. A write with a 1 in bit0 or bit3 clears that sticky bit; other bits are read-only.
  - 0x3 DBG_TX: write pushes data into the FIFO; read returns 0.
  - 0x4 SCRATCH: r/w, 32 bits.
  - 0x5..0xF: read 0, writes ignored.
- Counter:
  - Increments by 1 every cycle and wraps 32'hFFFFFFFF -> 0.
  - A CYCLE write takes priority over the increment.
- Timer:
  - When counter == TCMP and TCMP != 0, timer_hit is set on the next edge.
  - If a set and a write-1-clear land in the same cycle, set wins.
  - irq = timer_hit (registered).
- FIFO:
  - dbg_valid = ~empty; dbg_data = head entry; pop on dbg_valid & dbg_ready.
  - Push when a DBG_TX write arrives and (~full or pop in the same cycle).
  - Simultaneous push+pop while full: both happen and the count is unchanged.
  - Push while full with no pop: word dropped, overflow set.
  - Pointers wrap modulo FIFO_DEPTH; count is range 0..FIFO_DEPTH.
- Reset, synchronous:
  - counter = 0, TCMP = 0, SCRATCH = 0, timer_hit = 0, overflow = 0.
  - FIFO empty, sel_mmio = 0, rd_q = 0.
  - Outputs: dbg_valid = 0, irq = 0, q_dmem = mem_q.
  - Reset mid-transfer discards FIFO contents and any pending MMIO read.
  - While reset is high, mem_wren is forced to 0.

Optional Feature:
- Macro: MMIO_DBG_FIFO_EN.
- Defined: the debug TX FIFO is built as described above.
- Undefined:
  - No FIFO storage; DBG_TX writes are discarded and overflow is never set.
  - dbg_valid tied 0, dbg_data tied 0.
  - STATUS reads full = 0, empty = 1, count = 0.
  - dbg_ready is ignored.

Test Plan:
- Pass-through: write 32'hDEADBEEF to addr 12'h010, read it back -> mem_wren pulses 1 cycle; q_dmem = 32'hDEADBEEF one cycle after the read address.
- Counter: release reset, read CYCLE at cycle 10 -> 10; write CYCLE, then read 5 cycles later -> 4; preload near 32'hFFFFFFFF -> wraps to 0.
- Timer: TCMP = 20 after a counter clear -> timer_hit and irq rise the cycle after the count reaches 20. Write STATUS = 1 -> cleared. Clear in the same cycle as a new hit -> stays 1.
- FIFO (MMIO_DBG_FIFO_EN defined), dbg_ready = 0: push 5 words 1..5 -> STATUS full = 1, count = 4, overflow = 1. Then dbg_ready = 1 -> dbg_data sequence 1,2,3,4, then dbg_valid = 0.
- Full with simultaneous push+pop: word 9 accepted, count stays 4, no overflow.
- Map edges: read 12'hFEF -> mem_q path. Read 12'hFF7 -> 0. Write 12'hFF4 = 32'h5A5A5A5A -> reads back and mem_wren stays 0. Assert reset mid-sequence -> all registers 0 and dbg_valid = 0 on the next edge.
